// File: rtl/sr_mdu_pkg.sv
// sr_mdu_pkg: shared constants for the iterative multiply/divide unit.
//   - funct3 encodings of the RISC-V M extension (MDU_MUL .. MDU_REMU)
//   - FSM state encoding used by sr_mdu
//   - funct7 match for the M-extension opcode group, shared with sr_control
//   - helpers telling which operands of an op are interpreted as signed
package sr_mdu_pkg;

   localparam logic [2:0] MDU_MUL    = 3'd0;
   localparam logic [2:0] MDU_MULH   = 3'd1;
   localparam logic [2:0] MDU_MULHSU = 3'd2;
   localparam logic [2:0] MDU_MULHU  = 3'd3;
   localparam logic [2:0] MDU_DIV    = 3'd4;
   localparam logic [2:0] MDU_DIVU   = 3'd5;
   localparam logic [2:0] MDU_REM    = 3'd6;
   localparam logic [2:0] MDU_REMU   = 3'd7;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [6:0] RVF7_MULDIV = 7'b0000001;

   // MUL only needs the low half, which is sign-agnostic, so it runs unsigned.
   function automatic logic src_a_signed(input logic [2:0] op);
      return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
   endfunction

   function automatic logic src_b_signed(input logic [2:0] op);
      return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
   endfunction

endpackage

// File: rtl/sr_mdu_step.sv
// sr_mdu_step: one combinational iteration of the multiply/divide datapath.
//   Multiply: shift-add on {hi, lo}; lo holds the not-yet-consumed multiplier bits.
//   Divide:   restoring shift-subtract; hi is the partial remainder, lo shifts the
//             dividend out and the quotient bits in.
// Ports:
//   is_div   in   1     select divide step (1) or multiply step (0)
//   operand  in   XLEN  multiplicand (mul) or divisor magnitude (div)
//   hi, lo   in   XLEN  current accumulator halves
//   hi_nxt   out  XLEN  accumulator high half after this step
//   lo_nxt   out  XLEN  accumulator low half after this step
module sr_mdu_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] operand,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   output logic [XLEN-1:0] hi_nxt,
   output logic [XLEN-1:0] lo_nxt
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
      shifted = {hi, lo[XLEN-1]};
      // The partial remainder stays below the divisor, so diff[XLEN] is a clean borrow.
      diff    = shifted - {1'b0, operand};
      if (is_div) begin
         if (!diff[XLEN]) begin
            hi_nxt = diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b1};
         end else begin
            hi_nxt = shifted[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_nxt = sum[XLEN:1];
         lo_nxt = {sum[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/sr_mdu.sv
// sr_mdu: iterative RISC-V M-extension multiply/divide unit.
//   Operands are latched as magnitudes on start, STEP bits are retired per CALC
//   cycle, and the sign is restored in FIX before the result is registered.
// Ports:
//   clk     in   1     clock, rising edge
//   rst     in   1     synchronous active-high reset
//   start   in   1     launch request, honoured in IDLE or DONE
//   kill    in   1     abort an operation in CALC/FIX
//   op      in   3     funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   srcA    in   XLEN  rs1 (multiplicand / dividend)
//   srcB    in   XLEN  rs2 (multiplier / divisor)
//   busy    out  1     operation in flight
//   done    out  1     single-cycle pulse, result valid
//   result  out  XLEN  registered result, held until next completion
module sr_mdu
   import sr_mdu_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned STEP = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned N  = XLEN / STEP;
   localparam int unsigned CW = $clog2(N + 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic            neg_q, neg_d;
   logic [XLEN-1:0] opnd_q, opnd_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] result_q, result_d;

   // Operand conditioning at accept time.
   logic            a_neg, b_neg, res_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf;

   always_comb begin
      a_neg    = src_a_signed(op) & srcA[XLEN-1];
      b_neg    = src_b_signed(op) & srcB[XLEN-1];
      a_mag    = a_neg ? -srcA : srcA;
      b_mag    = b_neg ? -srcB : srcB;
      // Remainder follows the dividend; quotient and products follow the xor.
      res_neg  = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
      div_zero = (srcB == '0);
      div_ovf  = ((op == MDU_DIV) || (op == MDU_REM)) && (srcA == MIN_NEG) && (srcB == '1);
   end

   // STEP iterations chained combinationally per CALC cycle.
   logic [XLEN-1:0] hi_ch [STEP+1];
   logic [XLEN-1:0] lo_ch [STEP+1];

   assign hi_ch[0] = hi_q;
   assign lo_ch[0] = lo_q;

   for (genvar g = 0; g < STEP; g++) begin : g_step
      sr_mdu_step #(
         .XLEN (XLEN)
      ) u_step (
         .is_div  (op_q[2]),
         .operand (opnd_q),
         .hi      (hi_ch[g]),
         .lo      (lo_ch[g]),
         .hi_nxt  (hi_ch[g+1]),
         .lo_nxt  (lo_ch[g+1])
      );
   end

   // Sign correction and result selection.
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   div_sel, div_s, fix_val;

   always_comb begin
      prod    = {hi_q, lo_q};
      prod_s  = neg_q ? -prod : prod;
      div_sel = op_q[1] ? hi_q : lo_q;
      div_s   = neg_q ? -div_sel : div_sel;
      unique case (op_q)
         MDU_MUL:                          fix_val = prod_s[XLEN-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU:  fix_val = prod_s[2*XLEN-1:XLEN];
         default:                          fix_val = div_s;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               op_d = op;
               if (op[2] && (div_zero || div_ovf)) begin
                  // Architectural results preloaded: lo = quotient, hi = remainder.
                  state_d = ST_FIX;
                  neg_d   = 1'b0;
                  lo_d    = div_zero ? '1 : srcA;
                  hi_d    = div_zero ? srcA : '0;
               end else begin
                  state_d = ST_CALC;
                  cnt_d   = CW'(N);
                  neg_d   = res_neg;
                  hi_d    = '0;
                  opnd_d  = op[2] ? b_mag : a_mag;
                  lo_d    = op[2] ? a_mag : b_mag;
               end
            end
         end
         ST_CALC: begin
            if (kill) begin
               state_d = ST_IDLE;
            end else begin
               hi_d  = hi_ch[STEP];
               lo_d  = lo_ch[STEP];
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            if (kill) begin
               state_d = ST_IDLE;
            end else begin
               result_d = fix_val;
               state_d  = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;

endmodule

// File: tb/tb_sr_mdu.sv
// tb_sr_mdu: self-checking bench for sr_mdu. Three instances (STEP = 1, 2, 4)
// share one stimulus stream; results are compared against an arithmetic model.
module tb_sr_mdu;

   logic        clk;
   logic        rst;
   logic        start;
   logic        kill;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy_w [3];
   logic        done_w [3];
   logic [31:0] res_w  [3];

   int stp [3] = '{1, 2, 4};

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned S = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      sr_mdu #(
         .XLEN (32),
         .STEP (S)
      ) u_dut (
         .clk    (clk),
         .rst    (rst),
         .start  (start),
         .kill   (kill),
         .op     (op),
         .srcA   (src_a),
         .srcB   (src_b),
         .busy   (busy_w[g]),
         .done   (done_w[g]),
         .result (res_w[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int t0;
   int dn_cnt   [3];
   int first_cyc[3];
   int last_cyc [3];
   logic [31:0] first_res[3];
   logic [31:0] last_res [3];
   int bad [3];

   task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s step=%0d: observed %h expected %h", tag, stp[inst], obs, exp);
      end
   endtask

   // Behavioural model: plain 64-bit arithmetic on the architectural rules.
   function automatic logic [31:0] mdu_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'b0, a};
      ub = {32'b0, b};
      p  = '0;
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            p = sa % sb;
            return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int latency(input int inst, input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b);
      bit special;
      special = f[2] && ((b == 0) ||
                ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      return special ? 2 : (32 / stp[inst]) + 2;
   endfunction

   task automatic clear_log();
      for (int i = 0; i < 3; i++) begin
         dn_cnt[i] = 0;
         first_cyc[i] = -1;
         last_cyc[i] = -1;
         first_res[i] = 'x;
         last_res[i] = 'x;
         bad[i] = 0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (done_w[i] === 1'b1) begin
            if (dn_cnt[i] == 0) begin
               first_cyc[i] = cyc;
               first_res[i] = res_w[i];
            end
            last_cyc[i] = cyc;
            last_res[i] = res_w[i];
            dn_cnt[i]++;
         end
      end
   endtask

   // One operation on all instances: latency, busy window, single done, result, hold.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b);
      logic [31:0] expv;
      int lat [3];
      expv = mdu_model(f, a, b);
      for (int i = 0; i < 3; i++) lat[i] = latency(i, f, a, b);
      op = f; src_a = a; src_b = b; start = 1'b1;
      t0 = cyc;
      clear_log();
      for (int k = 1; k <= 35; k++) begin
         tick();
         if (k == 1) start = 1'b0;
         for (int i = 0; i < 3; i++)
            if (busy_w[i] !== (k < lat[i])) bad[i]++;
      end
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_busy"}, i, 32'(bad[i]), 32'd0);
         chk({tag, "_ndone"}, i, 32'(dn_cnt[i]), 32'd1);
         chk({tag, "_lat"}, i, 32'(first_cyc[i] - t0), 32'(lat[i]));
         chk({tag, "_res"}, i, first_res[i], expv);
         chk({tag, "_hold"}, i, res_w[i], expv);
      end
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 9))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         4:       return -32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; src_a = '0; src_b = '0;
      clear_log();
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
         chk("rst_done", i, 32'(done_w[i]), 32'd0);
         chk("rst_res", i, res_w[i], 32'd0);
      end
      rst = 1'b0;
      tick();

      run_op("mul", 3'd0, 32'd7, -32'd3);
      run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
      run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("div", 3'd4, -32'd7, 32'd2);
      run_op("rem", 3'd6, -32'd7, 32'd2);
      run_op("div0", 3'd4, 32'd5, 32'd0);
      run_op("rem0", 3'd6, 32'd5, 32'd0);
      run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divu", 3'd5, 32'd100, 32'd7);
      run_op("remu", 3'd7, 32'd100, 32'd7);

      // Kill at cycle 10: STEP 1/2 abort; STEP 4 is in DONE there, so kill is ignored.
      op = 3'd5; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
      t0 = cyc;
      clear_log();
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) start = 1'b0;
      end
      kill = 1'b1;
      tick();
      kill = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("kill_busy", i, 32'(busy_w[i]), 32'd0);
         chk("kill_done", i, 32'(done_w[i]), 32'd0);
         chk("kill_res", i, res_w[i], 32'd2);
      end
      chk("kill_ign_lat", 2, 32'(first_cyc[2] - t0), 32'd10);
      chk("kill_ign_res", 2, first_res[2], 32'd14);
      chk("kill_ign_busy", 2, 32'(busy_w[2]), 32'd0);
      for (int k = 0; k < 30; k++) tick();
      for (int i = 0; i < 2; i++) begin
         chk("kill_nodone", i, 32'(dn_cnt[i]), 32'd0);
         chk("kill_keep", i, res_w[i], 32'd2);
      end

      // Reset at cycle 10 mid-operation.
      op = 3'd0; src_a = 32'd7; src_b = -32'd3; start = 1'b1;
      clear_log();
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) start = 1'b0;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("mrst_busy", i, 32'(busy_w[i]), 32'd0);
         chk("mrst_done", i, 32'(done_w[i]), 32'd0);
         chk("mrst_res", i, res_w[i], 32'd0);
      end
      for (int k = 0; k < 40; k++) tick();
      for (int i = 0; i < 2; i++) chk("mrst_nodone", i, 32'(dn_cnt[i]), 32'd0);

      // Back-to-back: ignored start during CALC, new start in STEP=1's DONE cycle.
      op = 3'd0; src_a = 32'd7; src_b = -32'd3; start = 1'b1;
      t0 = cyc;
      clear_log();
      for (int k = 1; k <= 75; k++) begin
         tick();
         if (k == 35) chk("b2b_busy", 0, 32'(busy_w[0]), 32'd1);
         start = 1'b0;
         if (k == 5) begin
            op = 3'd5; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
         end
         if (k == 34) begin
            op = 3'd5; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
         end
      end
      for (int i = 0; i < 3; i++) begin
         chk("b2b_ndone", i, 32'(dn_cnt[i]), 32'd2);
         chk("b2b_lat1", i, 32'(first_cyc[i] - t0), 32'(32 / stp[i] + 2));
         chk("b2b_res1", i, first_res[i], 32'hFFFF_FFEB);
         chk("b2b_lat2", i, 32'(last_cyc[i] - t0), 32'(34 + 32 / stp[i] + 2));
         chk("b2b_res2", i, last_res[i], 32'd14);
      end

      for (int n = 0; n < 1200; n++) begin
         run_op("rnd", 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
